// File: rtl/beep_voice.sv
// beep_voice: single-voice square-wave tone generator with an
// attack/sustain/decay envelope, producing unsigned 16-bit audio samples.
//
// Ports:
//   clk           system clock
//   reset_in      asynchronous active-low reset
//   trigger       level input; a rising edge starts (or restarts) a note
//   tone_sel      pitch select, latched on the trigger edge
//                 (0=440 Hz, 1=660 Hz, 2=880 Hz, 3=1320 Hz)
//   mute          forces both audio outputs to midscale at the next sample
//   audio_l       unsigned left sample, updated on each sample tick
//   audio_r       unsigned right sample
//   sample_strobe one-cycle pulse in the first cycle new samples are visible
//   busy          high whenever the envelope is not idle
//
// Optional build macro:
//   BEEP_STEREO_EN  when defined, audio_r carries the inverted square wave;
//                   otherwise audio_r always equals audio_l.
module beep_voice #(
  parameter int SAMPLE_DIV    = 2083,
  parameter int ENV_DIV       = 64,
  parameter int SUSTAIN_TICKS = 375,
  parameter int ATTACK_STEP   = 8
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic        trigger,
  input  logic [1:0]  tone_sel,
  input  logic        mute,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        sample_strobe,
  output logic        busy
);

  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int EW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam int TW = (SUSTAIN_TICKS > 1) ? $clog2(SUSTAIN_TICKS) : 1;

  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [EW-1:0] ENV_LAST  = EW'(ENV_DIV - 1);
  localparam logic [TW-1:0] SUS_LAST  = TW'(SUSTAIN_TICKS - 1);
  localparam logic [8:0]    ATK_STEP  = 9'(ATTACK_STEP);
  localparam logic [15:0]   MIDSCALE  = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_SUSTAIN = 2'd2,
    ST_DECAY   = 2'd3
  } state_t;

  // Phase increment per sample for each pitch (f * 65536 / 48 kHz).
  function automatic logic [15:0] tone_inc(input logic [1:0] sel);
    logic [15:0] inc;
    case (sel)
      2'd0:    inc = 16'd601;
      2'd1:    inc = 16'd901;
      2'd2:    inc = 16'd1201;
      2'd3:    inc = 16'd1802;
      default: inc = 16'd601;
    endcase
    return inc;
  endfunction

  // Square-wave sample around midscale; amplitude is env scaled by 64.
  function automatic logic [15:0] sample_value(input logic [7:0] env, input logic upper);
    logic [15:0] amp;
    amp = {2'b00, env, 6'b000000};
    if (upper) begin
      return MIDSCALE + amp;
    end else begin
      return MIDSCALE - amp;
    end
  endfunction

  state_t        state_r, state_next_s;
  logic [SW-1:0] samp_cnt_r;
  logic [EW-1:0] env_cnt_r;
  logic [TW-1:0] sus_cnt_r, sus_cnt_next_s;
  logic          trig_q_r;
  logic [1:0]    tone_r;
  logic [15:0]   phase_r, phase_next_s;
  logic [7:0]    env_r, env_next_s;
  logic [8:0]    env_sum_s;
  logic [15:0]   audio_l_next_s, audio_r_next_s;
  logic          edge_s, tick_s, env_tick_s;

  assign edge_s     = trigger & ~trig_q_r;
  assign tick_s     = (samp_cnt_r == SAMP_LAST);
  assign env_tick_s = tick_s && (env_cnt_r == ENV_LAST);
  assign busy       = (state_r != ST_IDLE);
  assign env_sum_s  = {1'b0, env_r} + ATK_STEP;

  // Sample/envelope dividers, trigger edge register and tone latch.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      samp_cnt_r <= '0;
      env_cnt_r  <= '0;
      trig_q_r   <= 1'b0;
      tone_r     <= 2'd0;
    end else begin
      trig_q_r <= trigger;
      if (tick_s) begin
        samp_cnt_r <= '0;
      end else begin
        samp_cnt_r <= samp_cnt_r + 1'b1;
      end
      // A trigger edge realigns the envelope divider so the first attack
      // step always lands a full envelope period after the edge.
      if (edge_s) begin
        env_cnt_r <= '0;
        tone_r    <= tone_sel;
      end else if (tick_s) begin
        env_cnt_r <= (env_cnt_r == ENV_LAST) ? '0 : env_cnt_r + 1'b1;
      end else begin
        env_cnt_r <= env_cnt_r;
      end
    end
  end

  // Next-state, envelope and phase logic.
  always_comb begin
    state_next_s   = state_r;
    env_next_s     = env_r;
    sus_cnt_next_s = sus_cnt_r;
    phase_next_s   = phase_r;
    if (tick_s && (state_r != ST_IDLE)) begin
      phase_next_s = phase_r + tone_inc(tone_r);
    end else begin
      phase_next_s = phase_r;
    end
    // The trigger edge has priority; a coincident envelope tick is dropped.
    if (edge_s) begin
      state_next_s = ST_ATTACK;
    end else if (env_tick_s) begin
      case (state_r)
        ST_ATTACK: begin
          if (env_sum_s >= 9'd255) begin
            env_next_s     = 8'hFF;
            state_next_s   = ST_SUSTAIN;
            sus_cnt_next_s = '0;
          end else begin
            env_next_s = env_sum_s[7:0];
          end
        end
        ST_SUSTAIN: begin
          if (sus_cnt_r == SUS_LAST) begin
            state_next_s = ST_DECAY;
          end else begin
            sus_cnt_next_s = sus_cnt_r + 1'b1;
          end
        end
        ST_DECAY: begin
          if (env_r <= 8'd1) begin
            env_next_s   = 8'd0;
            state_next_s = ST_IDLE;
            phase_next_s = 16'd0;
          end else begin
            env_next_s = env_r - 8'd1;
          end
        end
        ST_IDLE: begin
          env_next_s = 8'd0;
        end
        default: begin
          state_next_s = ST_IDLE;
          env_next_s   = 8'd0;
          phase_next_s = 16'd0;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Output samples are built from the post-tick envelope and phase.
  always_comb begin
    audio_l_next_s = sample_value(env_next_s, phase_next_s[15]);
`ifdef BEEP_STEREO_EN
    audio_r_next_s = sample_value(env_next_s, ~phase_next_s[15]);
`else
    audio_r_next_s = audio_l_next_s;
`endif
  end

  // Envelope state register; phase/env/state advance only on sample ticks
  // except for the trigger-driven jump to ATTACK.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_r   <= ST_IDLE;
      env_r     <= 8'd0;
      sus_cnt_r <= '0;
      phase_r   <= 16'd0;
    end else begin
      state_r   <= state_next_s;
      env_r     <= env_next_s;
      sus_cnt_r <= sus_cnt_next_s;
      phase_r   <= phase_next_s;
    end
  end

  // Registered audio outputs and the strobe marking a fresh sample.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      audio_l       <= MIDSCALE;
      audio_r       <= MIDSCALE;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= tick_s;
      if (tick_s) begin
        audio_l <= mute ? MIDSCALE : audio_l_next_s;
        audio_r <= mute ? MIDSCALE : audio_r_next_s;
      end else begin
        audio_l <= audio_l;
        audio_r <= audio_r;
      end
    end
  end

endmodule

// File: tb/tb_beep_voice.sv
// Self-checking bench for beep_voice with small divider settings.
module tb_beep_voice;
  localparam int SD = 4;
  localparam int ED = 2;
  localparam int ST = 3;
  localparam int AS = 128;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic        trigger = 1'b0;
  logic [1:0]  tone_sel = 2'd0;
  logic        mute = 1'b0;
  logic [15:0] audio_l, audio_r;
  logic        sample_strobe, busy;

  beep_voice #(.SAMPLE_DIV(SD), .ENV_DIV(ED), .SUSTAIN_TICKS(ST), .ATTACK_STEP(AS)) dut (
    .clk(clk), .reset_in(reset_in), .trigger(trigger), .tone_sel(tone_sel), .mute(mute),
    .audio_l(audio_l), .audio_r(audio_r), .sample_strobe(sample_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model (sample-level behaviour, integer arithmetic).
  int INC [4] = '{601, 901, 1201, 1802};
  int m_state, m_env, m_phase, m_scnt, m_ecnt, m_sus, m_tone;
  bit m_trig_q, m_exp_strobe;
  bit m_edge, m_tick, m_etick;
  int n_state, n_env, n_phase;
  logic [31:0] sb_q [$];
  logic [31:0] sb_e;

  function automatic logic [15:0] expect_sample(int env, int ph, bit inv);
    int amp;
    bit hi;
    amp = env * 64;
    hi = ((ph >> 15) & 1) != 0;
    if (inv) hi = !hi;
    return hi ? 16'(32768 + amp) : 16'(32768 - amp);
  endfunction

  always @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      m_state = 0; m_env = 0; m_phase = 0; m_scnt = 0; m_ecnt = 0; m_sus = 0; m_tone = 0;
      m_trig_q = 0; m_exp_strobe = 0;
      sb_q.delete();
    end else begin
      m_edge  = trigger && !m_trig_q;
      m_tick  = (m_scnt == SD - 1);
      m_etick = m_tick && (m_ecnt == ED - 1);
      n_state = m_state; n_env = m_env; n_phase = m_phase;
      if (m_tick) begin
        if (m_state != 0) n_phase = (m_phase + INC[m_tone]) % 65536;
        if (m_etick && !m_edge) begin
          if (m_state == 1) begin
            n_env = m_env + AS;
            if (n_env >= 255) begin n_env = 255; n_state = 2; m_sus = 0; end
          end else if (m_state == 2) begin
            m_sus++;
            if (m_sus == ST) n_state = 3;
          end else if (m_state == 3) begin
            n_env = m_env - 1;
            if (n_env == 0) begin n_state = 0; n_phase = 0; end
          end
        end
        if (mute) sb_q.push_back(32'h80008000);
`ifdef BEEP_STEREO_EN
        else sb_q.push_back({expect_sample(n_env, n_phase, 0), expect_sample(n_env, n_phase, 1)});
`else
        else sb_q.push_back({expect_sample(n_env, n_phase, 0), expect_sample(n_env, n_phase, 0)});
`endif
      end
      if (m_edge) begin n_state = 1; m_tone = int'(tone_sel); end
      if (m_edge) m_ecnt = 0;
      else if (m_tick) m_ecnt = (m_ecnt + 1) % ED;
      m_scnt = (m_scnt + 1) % SD;
      m_trig_q = trigger;
      m_exp_strobe = m_tick;
      m_state = n_state; m_env = n_env; m_phase = n_phase;
    end
  end

  // Per-cycle checks and scoreboard pop on each strobe.
  always @(negedge clk) begin
    if (reset_in) begin
      check_vec("strobe", 32'(sample_strobe), 32'(m_exp_strobe));
      check_vec("busy", 32'(busy), 32'(m_state != 0));
      if (sample_strobe) begin
        if (sb_q.size() == 0) begin
          check_vec("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          sb_e = sb_q.pop_front();
          check_vec("audio_l", 32'(audio_l), 32'(sb_e[31:16]));
          check_vec("audio_r", 32'(audio_r), 32'(sb_e[15:0]));
`ifdef BEEP_STEREO_EN
          check_vec("lr_sum", 32'(audio_l) + 32'(audio_r), 32'h10000);
`endif
        end
      end
    end
  end

  task automatic wait_strobe(output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * SD + 2; i++) begin
      @(negedge clk);
      if (sample_strobe) begin ok = 1; break; end
    end
  endtask

  task automatic wait_state(input int st, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_state == st) begin ok = 1; break; end
    end
  endtask

  initial begin
    bit hit;
    bit ok;
    logic [15:0] dev;

    // Reset state
    repeat (3) @(negedge clk);
    check_vec("rst_audio_l", 32'(audio_l), 32'h8000);
    check_vec("rst_audio_r", 32'(audio_r), 32'h8000);
    check_vec("rst_busy", 32'(busy), 32'd0);
    check_vec("rst_strobe", 32'(sample_strobe), 32'd0);
    reset_in = 1'b1;
    repeat (13) @(negedge clk);

    // Note 1: full envelope at tone 0, with a mute window in sustain
    tone_sel = 2'd0;
    trigger = 1'b1;
    @(negedge clk);
    check_vec("busy_rise", 32'(busy), 32'd1);
    wait_state(2, 200, hit);
    check_vec("reach_sustain", 32'(hit), 32'd1);
    mute = 1'b1;
    wait_strobe(ok);
    check_vec("mute_strobe", 32'(ok), 32'd1);
    check_vec("mute_l", 32'(audio_l), 32'h8000);
    check_vec("mute_r", 32'(audio_r), 32'h8000);
    mute = 1'b0;
    wait_strobe(ok);
    dev = (audio_l >= 16'h8000) ? audio_l - 16'h8000 : 16'h8000 - audio_l;
    check_vec("unmute_amp", 32'(dev), 32'h3FC0);
    trigger = 1'b0;
    wait_state(0, 3000, hit);
    check_vec("reach_idle1", 32'(hit), 32'd1);
    check_vec("busy_fall", 32'(busy), 32'd0);

    // Note 2: retrigger in decay at env 200 with tone 3
    repeat (3) @(negedge clk);
    tone_sel = 2'd1;
    trigger = 1'b1;
    repeat (3) @(negedge clk);
    trigger = 1'b0;
    hit = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (m_state == 3 && m_env == 200) begin hit = 1; break; end
    end
    check_vec("reach_env200", 32'(hit), 32'd1);
    tone_sel = 2'd3;
    trigger = 1'b1;
    @(negedge clk);
    check_vec("retrig_busy", 32'(busy), 32'd1);
    wait_state(2, 100, hit);
    check_vec("retrig_sustain", 32'(hit), 32'd1);
    trigger = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset in the middle of a note
    @(posedge clk);
    #2 reset_in = 1'b0;
    #1;
    check_vec("arst_audio_l", 32'(audio_l), 32'h8000);
    check_vec("arst_audio_r", 32'(audio_r), 32'h8000);
    check_vec("arst_busy", 32'(busy), 32'd0);
    check_vec("arst_strobe", 32'(sample_strobe), 32'd0);
    @(negedge clk);
    reset_in = 1'b1;
    repeat (7) @(negedge clk);

    // Trigger edge coinciding with an envelope tick
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_scnt == SD - 1 && m_ecnt == ED - 1) begin hit = 1; break; end
    end
    check_vec("align_etick", 32'(hit), 32'd1);
    tone_sel = 2'd0;
    trigger = 1'b1;
    wait_strobe(ok);
    wait_strobe(ok);
    check_vec("coinc_s2", 32'(audio_l), 32'h8000);
    wait_strobe(ok);
    check_vec("coinc_s3", 32'(audio_l), 32'h6000);
    trigger = 1'b0;
    wait_state(0, 3000, hit);
    check_vec("reach_idle3", 32'(hit), 32'd1);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
